// File: rtl/bit64_multiply_coef.sv
// 64x32 signed multiply by a Q1.FRAC_BITS coefficient.
// Radix-2 Booth iteration, round-half-up rescale and saturation.
module bit64_multiply_coef #(
    parameter int FRAC_BITS = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in1,
    input  logic [31:0] coef,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out1,
    output logic        sat
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [96:0] RND = (97'd1 << FRAC_BITS) >> 1;

    state_t      state_q, state_d;
    logic [95:0] mcand_q, mcand_d;
    logic [95:0] acc_q, acc_d;
    logic [32:0] mplr_q, mplr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        fin_q, fin_d;
    logic [63:0] out1_q, out1_d;
    logic        sat_q, sat_d;

    logic [96:0] sum_w;
    logic [96:0] res_w;
    logic        ovf_pos;
    logic        ovf_neg;

    // Rescale the finished product at 97 bits and detect 64-bit overflow
    always_comb begin
        sum_w   = {acc_q[95], acc_q} + RND;
        res_w   = $signed(sum_w) >>> FRAC_BITS;
        ovf_pos = !res_w[96] && (|res_w[95:63]);
        ovf_neg = res_w[96] && !(&res_w[95:63]);
    end

    // Next-state, Booth step and result capture
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        out1_d  = out1_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    mcand_d = {{32{in1[63]}}, in1};
                    mplr_d  = {coef, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    fin_d   = 1'b0;
                end
            end
            BUSY: begin
                if (fin_q) begin
                    state_d = DONE;
                    fin_d   = 1'b0;
                    if (ovf_pos) begin
                        out1_d = 64'h7FFF_FFFF_FFFF_FFFF;
                        sat_d  = 1'b1;
                    end else if (ovf_neg) begin
                        out1_d = 64'h8000_0000_0000_0000;
                        sat_d  = 1'b1;
                    end else begin
                        out1_d = res_w[63:0];
                        sat_d  = 1'b0;
                    end
                end else begin
                    unique case (mplr_q[1:0])
                        2'b01:   acc_d = acc_q + mcand_q;
                        2'b10:   acc_d = acc_q - mcand_q;
                        default: acc_d = acc_q;
                    endcase
                    mcand_d = mcand_q << 1;
                    mplr_d  = {mplr_q[32], mplr_q[32:1]};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        fin_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            out1_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            out1_q  <= out1_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out1      = out1_q;
    assign sat       = sat_q;

endmodule

// File: doc/bit64_multiply_coef.md
BIT64_MULTIPLY_COEF -- requirements
Module: bit64_multiply_coef

Interface
REQ-001 Parameter FRAC_BITS, default 30, fractional bits of coef (Q1.FRAC_BITS); legal range 0..31.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in1/coef valid this cycle.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 in1  input  64  signed sample operand.
REQ-007 coef  input  32  signed coefficient, Q1.FRAC_BITS.
REQ-008 out_valid  output  1  out1/sat valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out1  output  64  signed scaled product.
REQ-011 sat  output  1  out1 was clipped.

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY, DONE; IDLE is the reset state.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; no operand overlap.
REQ-014 Accept = in_valid && in_ready at a rising edge: in1 and coef captured, IDLE->BUSY, 5-bit iteration counter cleared.
REQ-015 BUSY SHALL run exactly 32 cycles of radix-2 Booth recoding over coef bits (bit -1 = 0), building the exact 96-bit signed product in1*coef.
REQ-016 After the 32nd BUSY cycle the FSM SHALL enter DONE; out_valid rises exactly 33 rising edges after the accepting edge.
REQ-017 Scaling: R = (P + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic, round half toward +inf); for FRAC_BITS=0, R = P with no rounding term.
REQ-018 Rounding addition and shift SHALL be computed at 97-bit width; no intermediate wrap.
REQ-019 If R > 2^63-1, out1 = 0x7FFF_FFFF_FFFF_FFFF and sat=1; if R < -2^63, out1 = 0x8000_0000_0000_0000 and sat=1; else out1 = R[63:0], sat=0.
REQ-020 coef = -2^31 and in1 = -2^63 SHALL be handled exactly by REQ-015..019 (no special-casing errors).
REQ-021 In DONE, out1 and sat SHALL hold stable while out_ready=0 for any number of cycles.
REQ-022 out_valid && out_ready at an edge: DONE->IDLE; in_ready=1 the following cycle; earliest next accept is one edge later (throughput 1 result per 35 cycles).
REQ-023 in_valid, in1, coef changes during BUSY/DONE SHALL be ignored.
REQ-024 out1/sat SHALL retain the last result after leaving DONE until the next DONE (value not guaranteed meaningful while out_valid=0).

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force state IDLE, in_ready=1 after release, out_valid=0, out1=0, sat=0, counter=0, product accumulator=0.
REQ-026 Reset in BUSY or DONE SHALL abort the operation; no result is ever presented for the aborted operand pair.
REQ-027 First accept possible at the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-028 FRAC_BITS=30, in1=12345, coef=0x4000_0000 (1.0) -> out1=12345, sat=0, out_valid 33 edges after accept.
REQ-029 in1=-3, coef=0x2000_0000 (0.5) -> P>>30=-1.5, rounded -> out1=-1 (0xFFFF_FFFF_FFFF_FFFF), sat=0.
REQ-030 in1=-2^63, coef=-2^31 -> R=2^64 -> out1=0x7FFF_FFFF_FFFF_FFFF, sat=1; in1=2^62, coef=-2^31 -> R=-2^63 exact -> out1=0x8000_0000_0000_0000, sat=0.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> out1/sat/out_valid unchanged, in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
REQ-032 rst_n pulsed low at BUSY cycle 10 -> out_valid=0, out1=0 immediately; new operand after release returns its own correct result only.
REQ-033 Random in1/coef (10k pairs, FRAC_BITS 0, 15, 30, 31) against 97-bit reference model of REQ-017..019 -> exact match of out1 and sat.
